// File: rtl/eci_wod_rr_arb.sv
// eci_wod_rr_arb: round-robin packet-header arbiter with burst allowance and a one-entry output register.
// A zero burst count means no burst is in progress, so the first grant after reset always scans from last+1.
module eci_wod_rr_arb #(
   parameter int NUM_IN     = 4,
   parameter int HDR_WIDTH  = 64,
   parameter int SIZE_WIDTH = 5,
   parameter int VC_WIDTH   = 4,
   parameter int MAX_BURST  = 1,
   localparam int SW        = $clog2(NUM_IN)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_IN*HDR_WIDTH-1:0]  in_hdr_i,
   input  logic [NUM_IN*SIZE_WIDTH-1:0] in_pkt_size_i,
   input  logic [NUM_IN*VC_WIDTH-1:0]   in_pkt_vc_i,
   input  logic [NUM_IN-1:0]            in_pkt_valid_i,
   output logic [NUM_IN-1:0]            in_pkt_ready_o,
   output logic [HDR_WIDTH-1:0]         out_hdr_o,
   output logic [SIZE_WIDTH-1:0]        out_pkt_size_o,
   output logic [VC_WIDTH-1:0]          out_pkt_vc_o,
   output logic                         out_pkt_valid_o,
   input  logic                         out_pkt_ready_i,
   output logic [SW-1:0]                out_src_o
);
   localparam logic [3:0] MB = 4'(MAX_BURST);
   logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic [VC_WIDTH-1:0]   vc_q, vc_d;
   logic                  valid_q, valid_d;
   logic [SW-1:0]         src_q, src_d, last_q, last_d, sel, idx;
   logic [3:0]            burst_q, burst_d;
   logic                  grant;
   assign grant = reset_n && (!valid_q || out_pkt_ready_i) && (|in_pkt_valid_i);
   assign in_pkt_ready_o = {NUM_IN{grant}} & (NUM_IN'(1) << sel);
   assign out_hdr_o = hdr_q;
   assign out_pkt_size_o = size_q;
   assign out_pkt_vc_o = vc_q;
   assign out_pkt_valid_o = valid_q;
   assign out_src_o = src_q;
   // Descending scan so the nearest valid index after last wins; last itself is reached on wrap.
   always_comb begin
      sel = last_q;
      idx = last_q;
      for (int i = NUM_IN; i >= 1; i--) begin
         idx = SW'((int'(last_q) + i) % NUM_IN);
         if (in_pkt_valid_i[idx]) sel = idx;
      end
      if (burst_q != 4'd0 && burst_q < MB && in_pkt_valid_i[last_q]) sel = last_q;
   end
   always_comb begin
      hdr_d = hdr_q;
      size_d = size_q;
      vc_d = vc_q;
      valid_d = valid_q;
      src_d = src_q;
      last_d = last_q;
      burst_d = burst_q;
      if (grant) begin
         hdr_d = in_hdr_i[sel*HDR_WIDTH +: HDR_WIDTH];
         size_d = in_pkt_size_i[sel*SIZE_WIDTH +: SIZE_WIDTH];
         vc_d = in_pkt_vc_i[sel*VC_WIDTH +: VC_WIDTH];
         valid_d = 1'b1;
         src_d = sel;
         last_d = sel;
         burst_d = (sel == last_q) ? ((burst_q >= MB) ? MB : burst_q + 4'd1) : 4'd1;
      end else if (out_pkt_ready_i) begin
         valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hdr_q <= '0;
         size_q <= '0;
         vc_q <= '0;
         valid_q <= 1'b0;
         src_q <= '0;
         last_q <= SW'(NUM_IN - 1);
         burst_q <= 4'd0;
      end else begin
         hdr_q <= hdr_d;
         size_q <= size_d;
         vc_q <= vc_d;
         valid_q <= valid_d;
         src_q <= src_d;
         last_q <= last_d;
         burst_q <= burst_d;
      end
   end
endmodule

// File: tb/tb_eci_wod_rr_arb.sv
// tb_eci_wod_rr_arb: directed arbitration checks plus a scoreboarded random valid/ready stress run.
module tb_eci_wod_rr_arb;
   typedef struct packed {
      logic [63:0] h;
      logic [4:0]  s;
      logic [3:0]  v;
      logic [1:0]  src;
   } pkt_t;
   logic         clk = 1'b0;
   logic         reset_n;
   logic [3:0]   vld;
   logic         ordy;
   logic [63:0]  hdr[4];
   logic [4:0]   sz[4];
   logic [3:0]   vc[4];
   logic [255:0] in_hdr;
   logic [19:0]  in_sz;
   logic [15:0]  in_vc;
   logic [3:0]   rdy1, rdy3, acc;
   logic [63:0]  ohdr1, ohdr3;
   logic [4:0]   osz1, osz3;
   logic [3:0]   ovc1, ovc3;
   logic         oval1, oval3;
   logic [1:0]   osrc1, osrc3;
   int           n_chk = 0, n_pass = 0;
   int           wait_c[4];
   int           seq[4];
   pkt_t         q[$];
   pkt_t         p;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 4; g++) begin : g_pack
      assign in_hdr[g*64 +: 64] = hdr[g];
      assign in_sz[g*5 +: 5] = sz[g];
      assign in_vc[g*4 +: 4] = vc[g];
   end
   eci_wod_rr_arb #(.MAX_BURST(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_hdr_i(in_hdr), .in_pkt_size_i(in_sz),
      .in_pkt_vc_i(in_vc), .in_pkt_valid_i(vld), .in_pkt_ready_o(rdy1),
      .out_hdr_o(ohdr1), .out_pkt_size_o(osz1), .out_pkt_vc_o(ovc1),
      .out_pkt_valid_o(oval1), .out_pkt_ready_i(ordy), .out_src_o(osrc1)
   );
   eci_wod_rr_arb #(.MAX_BURST(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .in_hdr_i(in_hdr), .in_pkt_size_i(in_sz),
      .in_pkt_vc_i(in_vc), .in_pkt_valid_i(vld), .in_pkt_ready_o(rdy3),
      .out_hdr_o(ohdr3), .out_pkt_size_o(osz3), .out_pkt_vc_o(ovc3),
      .out_pkt_valid_o(oval3), .out_pkt_ready_i(ordy), .out_src_o(osrc3)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse_rst();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask
   // Monitor sits on the falling edge: inputs and DUT outputs are stable for the coming rising edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         q.delete();
         acc = '0;
         for (int k = 0; k < 4; k++) wait_c[k] = 0;
      end else begin
         acc = rdy1 & vld;
         chk("rdy_onehot", 64'($onehot0(rdy1)), 1);
         chk("rdy_only_valid", 64'(rdy1 & ~vld), 0);
         if (oval1 && !ordy) chk("stall_rdy", 64'(rdy1), 0);
         if (oval1 && ordy) begin
            chk("q_nonempty", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
               p = q.pop_front();
               chk("sb_hdr", ohdr1, p.h);
               chk("sb_size", 64'(osz1), 64'(p.s));
               chk("sb_vc", 64'(ovc1), 64'(p.v));
               chk("sb_src", 64'(osrc1), 64'(p.src));
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
               chk("starve", 64'(wait_c[k] <= 3), 1);
               wait_c[k] = 0;
               q.push_back({hdr[k], sz[k], vc[k], 2'(k)});
            end else if (vld[k]) wait_c[k] += int'(acc != 0);
            else wait_c[k] = 0;
         end
      end
   end
   initial begin
      int e32[5];
      int e33[10];
      e32 = '{0, 1, 2, 3, 0};
      e33 = '{1, 1, 1, 2, 2, 2, 1, 1, 1, 2};
      reset_n = 1'b0;
      ordy = 1'b1;
      vld = 4'hf;
      for (int k = 0; k < 4; k++) begin
         hdr[k] = 64'(k);
         sz[k] = 5'(k + 1);
         vc[k] = 4'(k + 8);
         seq[k] = 0;
      end
      #1;
      chk("rst_valid", 64'(oval1), 0);
      chk("rst_hdr", ohdr1, 0);
      chk("rst_size", 64'(osz1), 0);
      chk("rst_vc", 64'(ovc1), 0);
      chk("rst_src", 64'(osrc1), 0);
      chk("rst_rdy", 64'(rdy1), 0);
      tick();
      tick();
      chk("rst_rdy_held", 64'(rdy1), 0);
      reset_n = 1'b1;
      #1;
      chk("rr_first_rdy", 64'(rdy1), 64'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_src", 64'(osrc1), 64'(e32[i]));
         chk("rr_hdr", ohdr1, 64'(e32[i]));
         chk("rr_valid", 64'(oval1), 1);
      end
      chk("rr_next_rdy", 64'(rdy1), 64'h2);
      vld = 4'b0110;
      pulse_rst();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("burst3_src", 64'(osrc3), 64'(e33[i]));
         chk("burst3_hdr", ohdr3, 64'(e33[i]));
      end
      vld = 4'b0000;
      pulse_rst();
      hdr[2] = 64'hDEAD_BEEF_0000_0002;
      sz[2] = 5'd3;
      vc[2] = 4'd6;
      ordy = 1'b0;
      vld = 4'b0100;
      tick();
      chk("hold_load_valid", 64'(oval1), 1);
      chk("hold_load_src", 64'(osrc1), 2);
      vld = 4'b1011;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_rdy", 64'(rdy1), 0);
         tick();
         chk("hold_hdr", ohdr1, 64'hDEAD_BEEF_0000_0002);
         chk("hold_size", 64'(osz1), 3);
         chk("hold_vc", 64'(ovc1), 6);
         chk("hold_src", 64'(osrc1), 2);
         chk("hold_valid", 64'(oval1), 1);
      end
      vld = 4'b0000;
      ordy = 1'b1;
      tick();
      chk("hold_drained", 64'(oval1), 0);
      vld = 4'b1000;
      pulse_rst();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wrap_src", 64'(osrc1), 3);
         chk("wrap_valid", 64'(oval1), 1);
         chk("wrap_rdy", 64'(rdy1), 64'h8);
      end
      vld = 4'b0001;
      ordy = 1'b0;
      pulse_rst();
      tick();
      chk("midrst_pre_valid", 64'(oval1), 1);
      chk("midrst_pre_src", 64'(osrc1), 0);
      vld = 4'b0110;
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(oval1), 0);
      chk("midrst_rdy", 64'(rdy1), 0);
      chk("midrst_hdr", ohdr1, 0);
      tick();
      reset_n = 1'b1;
      ordy = 1'b1;
      #1;
      chk("midrst_rdy_after", 64'(rdy1), 64'h2);
      tick();
      chk("midrst_src_after", 64'(osrc1), 1);
      vld = 4'b0000;
      pulse_rst();
      for (int c = 0; c < 800; c++) begin
         tick();
         ordy = ($urandom_range(0, 9) < 7);
         for (int k = 0; k < 4; k++) begin
            if (!vld[k] || acc[k]) begin
               vld[k] = ($urandom_range(0, 2) != 0);
               seq[k]++;
               hdr[k] = {32'(k), 32'(seq[k])};
               sz[k] = 5'($urandom);
               vc[k] = 4'($urandom);
            end
         end
      end
      vld = 4'b0000;
      ordy = 1'b1;
      tick();
      tick();
      chk("drain_q", 64'(q.size()), 0);
      chk("drain_valid", 64'(oval1), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/eci_wod_rr_arb.md
ECI_WOD_RR_ARB -- requirements
Module: eci_wod_rr_arb

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of requester channels (2..8).
REQ-002 SHALL have parameter HDR_WIDTH, default 64 (ECI_WORD_WIDTH), header width.
REQ-003 SHALL have parameter SIZE_WIDTH, default 5 (ECI_PACKET_SIZE_WIDTH), packet size width.
REQ-004 SHALL have parameter VC_WIDTH, default 4, VC field width.
REQ-005 SHALL have parameter MAX_BURST, default 1, max consecutive grants to one requester (1..15).
REQ-006 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_hdr_i, input, NUM_IN*HDR_WIDTH, requester headers; requester k at bits [k*HDR_WIDTH +: HDR_WIDTH].
REQ-009 SHALL have port in_pkt_size_i, input, NUM_IN*SIZE_WIDTH, requester sizes, same packing.
REQ-010 SHALL have port in_pkt_vc_i, input, NUM_IN*VC_WIDTH, requester VCs, same packing.
REQ-011 SHALL have port in_pkt_valid_i, input, NUM_IN, per-requester valid.
REQ-012 SHALL have port in_pkt_ready_o, output, NUM_IN, per-requester ready.
REQ-013 SHALL have port out_hdr_o, output, HDR_WIDTH, granted header.
REQ-014 SHALL have port out_pkt_size_o, output, SIZE_WIDTH, granted size.
REQ-015 SHALL have port out_pkt_vc_o, output, VC_WIDTH, granted VC.
REQ-016 SHALL have port out_pkt_valid_o, output, 1, output valid.
REQ-017 SHALL have port out_pkt_ready_i, input, 1, downstream ready.
REQ-018 SHALL have port out_src_o, output, $clog2(NUM_IN), index of requester that supplied current output.

Function
REQ-019 SHALL transfer on a channel only when valid and ready are both high in the same cycle.
REQ-020 SHALL hold a one-entry output register; load_en = !out_pkt_valid_o || out_pkt_ready_i.
REQ-021 SHALL assert at most one in_pkt_ready_o bit per cycle: bit g high iff load_en and g is the selected requester and in_pkt_valid_i[g]; in_pkt_ready_o SHALL NOT depend combinationally on any non-selected input besides the valid vector.
REQ-022 Selection: if burst_cnt < MAX_BURST and in_pkt_valid_i[last] then g = last; else g = first valid index scanning last+1, last+2, ... modulo NUM_IN (wrap to 0 after NUM_IN-1).
REQ-023 On a load, SHALL register hdr/size/vc of g into outputs, set out_pkt_valid_o=1, out_src_o=g, last=g, burst_cnt = (g==last) ? min(burst_cnt+1, MAX_BURST) : 1.
REQ-024 If out_pkt_valid_o && out_pkt_ready_i and no requester valid, SHALL clear out_pkt_valid_o; burst_cnt and last unchanged.
REQ-025 Simultaneous output accept and new load SHALL replace the register in the same cycle (full throughput, 1 packet/cycle).
REQ-026 Latency SHALL be exactly 1 cycle from input handshake to out_pkt_valid_o.
REQ-027 While out_pkt_valid_o && !out_pkt_ready_i, all out_* SHALL remain stable and all in_pkt_ready_o SHALL be 0.
REQ-028 No valid inputs with load_en: no state change except REQ-024.
REQ-029 Packet fields SHALL pass unmodified; no reordering within one requester.

Reset
REQ-030 On reset_n low, asynchronously: out_pkt_valid_o=0, out_hdr_o/size/vc=0, out_src_o=0, last=NUM_IN-1 (so requester 0 has first priority), burst_cnt=0; in_pkt_ready_o=0 while reset asserted.
REQ-031 Reset mid-transfer SHALL discard the held packet; first post-reset grant follows REQ-022 from last=NUM_IN-1.

Verification
REQ-032 After reset, all 4 valid, out_ready=1, MAX_BURST=1 -> grants 0,1,2,3,0 on consecutive cycles, out_src_o matches, one packet/cycle.
REQ-033 MAX_BURST=3, requesters 1 and 2 always valid -> output sources 1,1,1,2,2,2,1,...
REQ-034 Requester 2 sends hdr 0xDEAD_BEEF_0000_0002, size 3, vc 6; out_ready held 0 for 5 cycles -> outputs stable, all in_ready 0, then delivered once when ready=1.
REQ-035 Only requester 3 valid, last=3 at MAX_BURST reached -> scan wraps 0,1,2,3 and grants 3 (no stall).
REQ-036 reset_n pulsed low while out_pkt_valid_o=1 -> out_pkt_valid_o=0 immediately, next grant to lowest valid index.
REQ-037 Random valid/ready stress, NUM_IN=4 -> scoreboard: no loss, no duplicates, per-requester order preserved, no requester starved beyond (NUM_IN-1)*MAX_BURST output transfers.
